// File: rtl/iter_branch_cmp_if.sv
// rtl/iter_branch_cmp_if.sv - request/result bundle for the iterative branch comparator
interface iter_branch_cmp_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [3:0]       cmpOp;
    logic             busy;
    logic             done;
    logic             branch;

    modport master (
        output start, flush, srcA, srcB, cmpOp,
        input  busy, done, branch
    );

    modport slave (
        input  start, flush, srcA, srcB, cmpOp,
        output busy, done, branch
    );
endinterface

// File: rtl/iter_branch_cmp.sv
// rtl/iter_branch_cmp.sv - slice-serial branch comparator, MSB slice first, optional early exit
module iter_branch_cmp #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int EARLY = 1
) (
    input  logic           clk,
    input  logic           reset,
    iter_branch_cmp_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             sgn_q, sgn_d;
    logic             branch_q, branch_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_eff, b_eff;
    logic [SLICE-1:0] slice_a, slice_b;
    logic             diff, eq_n, lt_n, valid_op, finish, accept;

    function automatic logic branch_fn(input logic [3:0] op, input logic eq, input logic lt);
        case (op)
            4'd1:    branch_fn = eq;
            4'd2:    branch_fn = !eq;
            4'd3:    branch_fn = lt | eq;
            4'd4:    branch_fn = !lt & !eq;
            4'd5:    branch_fn = lt;
            4'd6:    branch_fn = !lt;
            4'd7:    branch_fn = lt;
            4'd8:    branch_fn = lt;
            4'd9:    branch_fn = !lt;
            4'd10:   branch_fn = !lt;
            default: branch_fn = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sgn_q    <= 1'b0;
            branch_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sgn_q    <= sgn_d;
            branch_q <= branch_d;
            done_q   <= done_d;
        end
    end

    // Flipping the sign bit turns a signed compare into an unsigned one; it only lands in the top slice.
    always_comb begin
        a_eff            = a_q;
        b_eff            = b_q;
        a_eff[WIDTH-1]   = a_q[WIDTH-1] ^ sgn_q;
        b_eff[WIDTH-1]   = b_q[WIDTH-1] ^ sgn_q;
        slice_a          = a_eff[int'(cnt_q)*SLICE +: SLICE];
        slice_b          = b_eff[int'(cnt_q)*SLICE +: SLICE];
        diff             = (slice_a != slice_b);
        eq_n             = eq_q;
        lt_n             = lt_q;
        if (eq_q && diff) begin
            eq_n = 1'b0;
            lt_n = (slice_a < slice_b);
        end
        // Reserved opcodes always run the full latency.
        valid_op = (op_q <= 4'd10);
        finish   = (cnt_q == '0) || ((EARLY != 0) && valid_op && eq_q && diff);
        accept   = bus.start && !bus.flush;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (bus.flush || finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        branch_d = branch_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                a_d   = bus.srcA;
                b_d   = (bus.cmpOp >= 4'd3 && bus.cmpOp <= 4'd6) ? '0 : bus.srcB;
                op_d  = bus.cmpOp;
                sgn_d = (bus.cmpOp >= 4'd3 && bus.cmpOp <= 4'd7) || (bus.cmpOp == 4'd9);
                cnt_d = CW'(NSLICE - 1);
                eq_d  = 1'b1;
                lt_d  = 1'b0;
            end
        end else if (!bus.flush) begin
            eq_d = eq_n;
            lt_d = lt_n;
            if (finish) begin
                branch_d = branch_fn(op_q, eq_n, lt_n);
                done_d   = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_comb begin
        bus.busy   = (state_q == RUN);
        bus.done   = done_q;
        bus.branch = branch_q;
    end
endmodule

// File: tb/tb_iter_branch_cmp.sv
// tb/tb_iter_branch_cmp.sv - scoreboard bench driving an EARLY=0 and an EARLY=1 comparator in lockstep
module tb_iter_branch_cmp;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic br;
        int   cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    iter_branch_cmp_if #(.WIDTH(32)) if0();
    iter_branch_cmp_if #(.WIDTH(32)) if1();

    iter_branch_cmp #(.WIDTH(32), .SLICE(8), .EARLY(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave)
    );
    iter_branch_cmp #(.WIDTH(32), .SLICE(8), .EARLY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
        if0.start = st; if0.flush = fl; if0.srcA = a; if0.srcB = b; if0.cmpOp = op;
        if1.start = st; if1.flush = fl; if1.srcA = a; if1.srcB = b; if1.cmpOp = op;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input int k1, input logic br, input logic push);
        drive(1'b1, 1'b0, a, b, op);
        if (push) begin
            q0.push_back('{br: br, cyc: cyc + 1 + 4});
            q1.push_back('{br: br, cyc: cyc + 1 + k1});
        end
        @(negedge clk);
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!if0.busy && !if1.busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (if0.done) begin
                if (q0.size() == 0) chk("dut0_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("dut0_branch", {31'd0, if0.branch}, {31'd0, e.br});
                    chk("dut0_done_cycle", cyc, e.cyc);
                end
            end
            if (if1.done) begin
                if (q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("dut1_branch", {31'd0, if1.branch}, {31'd0, e.br});
                    chk("dut1_done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic got;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #12;
        chk("rst_busy0", {31'd0, if0.busy}, 32'd0);
        chk("rst_done0", {31'd0, if0.done}, 32'd0);
        chk("rst_branch0", {31'd0, if0.branch}, 32'd0);
        chk("rst_busy1", {31'd0, if1.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(32'h12345678, 32'h12345678, 4'd1, 4, 1'b1, 1'b1);
        chk("t1_busy_after_start", {31'd0, if0.busy}, 32'd1);
        wait_idle("t1_idle");

        issue(32'h80000000, 32'h7FFFFFFF, 4'd8, 1, 1'b0, 1'b1);
        wait_idle("t2_ltu_idle");
        issue(32'h80000000, 32'h7FFFFFFF, 4'd7, 1, 1'b1, 1'b1);
        wait_idle("t2_lt_idle");

        issue(32'h00000001, 32'h00000000, 4'd2, 4, 1'b1, 1'b1);
        wait_idle("t3_ne_idle");
        issue(32'hFFFFFFFF, 32'h12345678, 4'd3, 1, 1'b1, 1'b1);
        wait_idle("t3_lez_idle");

        issue(32'd5, 32'd5, 4'd9, 4, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'd0, 32'd1, 4'd9);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 32'd1, 4'd9);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if0.done) begin
                got = 1'b1;
                break;
            end
        end
        chk("t4_done_seen", {31'd0, got}, 32'd1);
        issue(32'd3, 32'd4, 4'd10, 4, 1'b0, 1'b1);
        wait_idle("t4_geu_idle");

        issue(32'd7, 32'd7, 4'd1, 4, 1'b1, 1'b1);
        wait_idle("pre_flush_idle");
        @(negedge clk);

        issue(32'h00000001, 32'h00000000, 4'd2, 4, 1'b1, 1'b0);
        if0.flush = 1'b1; if1.flush = 1'b1;
        @(negedge clk);
        if0.flush = 1'b0; if1.flush = 1'b0;
        chk("t5_flush_busy0", {31'd0, if0.busy}, 32'd0);
        chk("t5_flush_busy1", {31'd0, if1.busy}, 32'd0);
        chk("t5_flush_branch0", {31'd0, if0.branch}, 32'd1);
        chk("t5_flush_branch1", {31'd0, if1.branch}, 32'd1);
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b1, 32'd1, 32'd2, 4'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd1, 32'd2, 4'd1);
        chk("t5_start_flush_busy0", {31'd0, if0.busy}, 32'd0);
        chk("t5_start_flush_busy1", {31'd0, if1.busy}, 32'd0);
        @(negedge clk);

        issue(32'hFF000000, 32'h00000000, 4'd2, 1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy0", {31'd0, if0.busy}, 32'd0);
        chk("t6_rst_done0", {31'd0, if0.done}, 32'd0);
        chk("t6_rst_branch0", {31'd0, if0.branch}, 32'd0);
        chk("t6_rst_busy1", {31'd0, if1.busy}, 32'd0);
        chk("t6_rst_branch1", {31'd0, if1.branch}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(32'd0, 32'd0, 4'd1, 4, 1'b1, 1'b1);
        wait_idle("t6_eq_idle");
        @(negedge clk);
        issue(32'h80000000, 32'h00000000, 4'd13, 4, 1'b0, 1'b1);
        wait_idle("t6_op13_idle");
        repeat (3) @(negedge clk);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
